mem_access: RTL
===============

# mem_access

Load/store unit that sits directly downstream of the execute stage in the single-cycle RISC-V core. It takes the ALU result (`alu_c`) as the effective address and `rD2` as store data. It runs a request/acknowledge transaction on the data bus and stalls the core until the access completes. It returns sign- or zero-extended load data to writeback, and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in BUS waiting for `dbus_ack`. 0 disables the timeout.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  in  1  current instruction is a load or store (level, from control).
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `mem_unsigned`  in  1  loads only: zero-extend (lbu/lhu) instead of sign-extend.
- `alu_c`  in  32  effective byte address.
- `rD2`  in  32  store data (low bits used for byte/half).
- `stall`  out  1  combinational; holds PC and register-file write while high.
- `done`  out  1  one-cycle pulse in the DONE state.
- `rd_data`  out  32  extended load data; held until the next `done`.
- `misalign`  out  1  valid with `done`.
- `bus_err`  out  1  valid with `done`.
- `dbus_req`  out  1  registered bus request.
- `dbus_we`  out  1  registered write enable.
- `dbus_addr`  out  32  registered word-aligned address ({addr[31:2],2'b00}).
- `dbus_wstrb`  out  4  registered byte strobes.
- `dbus_wdata`  out  32  registered lane-replicated store data.
- `dbus_ack`  in  1  slave completes the transfer on a cycle where `dbus_req`=1.
- `dbus_rdata`  in  32  read word, valid when `dbus_ack`=1.

## Operation
- FSM states: IDLE, BUS, DONE.
- **IDLE → BUS:** `mem_req`=1 and the access is aligned. The unit latches addr, we, size and unsigned, loads `dbus_*`, and clears the timeout counter.
- **IDLE → DONE (no bus traffic):** `mem_req`=1 and the access is misaligned. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size=3. The unit sets `misalign`=1.
- **BUS → DONE on `dbus_ack`=1:** `dbus_req` drops. For loads, `rd_data` is captured from `dbus_rdata`.
- **BUS → DONE on timeout:** when the counter reaches TIMEOUT-1 with no ack, `bus_err`=1 and `rd_data`=0.
- **DONE → IDLE:** unconditional. `mem_req` is ignored in DONE; it still belongs to the finishing instruction.
- `stall` = (state==IDLE & `mem_req`) | (state==BUS). `stall` is 0 in DONE.
- **Store strobes:**
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- **Store data:**
  - byte: `rD2[7:0]` replicated ×4
  - half: `rD2[15:0]` replicated ×2
  - word: `rD2`
- **Loads:** `dbus_wstrb`=0. Lane is selected by addr[1:0] (byte) or addr[1] (half), then extended from bit 7 or bit 15, or zero-extended if `mem_unsigned`.
- `misalign` and `bus_err` are cleared on the next accepted request.

## Timing
- **Reset values:**
  - state IDLE
  - `dbus_req`, `dbus_we`, `done`, `misalign` and `bus_err` = 0
  - `dbus_addr`, `dbus_wdata`, `dbus_wstrb` and `rd_data` = 0
- **Aligned access with zero-wait ack:**
  - T0: IDLE, `stall`=1.
  - T1: BUS, `dbus_req`=1, `dbus_ack`=1.
  - T2: DONE, `done`=1, `stall`=0.
  - Total 3 cycles, 2 stalled.
- Each extra wait cycle adds one cycle.
- **Misaligned access:** T0 IDLE with `stall`=1, T1 DONE with `misalign`=1. `dbus_req` never rises.
- **Timeout:** the unit spends exactly TIMEOUT cycles in BUS, then DONE.
- **Ack on the same edge as the timeout limit:** the ack wins, and `bus_err`=0.
- `dbus_*` are stable for the whole BUS state. An ack while `dbus_req`=0 is ignored.
- **`rst` mid-BUS:** next edge gives IDLE with `dbus_req`=0. The transaction is abandoned and `done` does not pulse.
- **Back-to-back memory instructions:** a new request is accepted in the IDLE cycle right after DONE (one DONE cycle per access).

## Test plan
- **Word store, ack after 2 waits:** addr=0x104, rD2=0xDEADBEEF.
  - `dbus_addr`=0x104, `dbus_wstrb`=4'hF, `dbus_wdata`=0xDEADBEEF.
  - `stall` high 4 cycles, then a `done` pulse.
- **Byte stores to addr 0x201..0x203 with rD2=0x000000A5:**
  - strobes 4'b0010, 4'b0100, 4'b1000
  - `dbus_wdata`=0xA5A5A5A5
  - `dbus_addr`=0x200
- **Load sign/zero extension:** `dbus_rdata`=0x80F07F81 at addr 0x200.
  - lb → 0xFFFFFF81
  - lbu, addr 0x203 → 0x00000080
  - lh, addr 0x202 → 0xFFFF80F0
  - lhu, addr 0x200 → 0x00007F81
  - lw → 0x80F07F81
- **Misaligned lw at 0x102 and lh at 0x101:** `misalign`=1 with `done` on T1, `dbus_req` stays 0, `stall` high 1 cycle.
- **TIMEOUT=4, no ack:** `dbus_req` high exactly 4 cycles, then `done`=1, `bus_err`=1, `rd_data`=0. The next aligned load clears `bus_err`.
- **`rst` asserted in BUS:** next cycle state is IDLE, `dbus_req`=0, `stall` follows `mem_req`, and no `done` pulse occurs.

Source files
------------

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- load/store unit behind the execute stage.
//
// Takes the ALU result as the effective byte address and rD2 as store data.
// Runs one request/acknowledge transfer on the data bus per memory instruction.
// Holds the core in stall until the access finishes. Returns extended load
// data, and flags misaligned or timed-out accesses.
//
// Parameters
//   TIMEOUT      max cycles spent in BUS waiting for dbus_ack (0 = no limit)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   mem_req      current instruction is a load or store (level)
//   mem_we       1 = store, 0 = load
//   mem_size     0 byte, 1 half, 2 word, 3 illegal
//   mem_unsigned zero-extend loads (lbu/lhu)
//   alu_c        effective byte address
//   rD2          store data
//   stall        combinational; freezes PC / register-file write
//   done         one-cycle pulse in DONE
//   rd_data      extended load data, held until the next done
//   misalign     access rejected as misaligned (valid with done)
//   bus_err      access timed out (valid with done)
//   dbus_req     registered bus request
//   dbus_we      registered write enable
//   dbus_addr    registered word-aligned address
//   dbus_wstrb   registered byte strobes (0 for loads)
//   dbus_wdata   registered lane-replicated store data
//   dbus_ack     slave completes the transfer while dbus_req = 1
//   dbus_rdata   read word, valid with dbus_ack
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for mem_req; misaligned requests go straight to DONE
// BUS    | dbus_req held, waiting for ack or timeout
// DONE   | done pulse, core released; mem_req ignored for this cycle
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_c,
    input  logic [31:0] rD2,
    output logic        stall,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Down-counter loaded with TIMEOUT-1 on entry to BUS; reaching zero
    // without an ack means exactly TIMEOUT cycles have been spent in BUS.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          uns_q;

    logic          req_misaligned;
    logic [3:0]    strb_next;
    logic [31:0]   wdata_next;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_data;

    assign stall = ((state == S_IDLE) && mem_req) || (state == S_BUS);

    always_comb begin
        req_misaligned = 1'b0;
        strb_next      = 4'b1111;
        wdata_next     = rD2;
        case (mem_size)
            2'd0: begin
                strb_next  = 4'b0001 << alu_c[1:0];
                wdata_next = {4{rD2[7:0]}};
            end
            2'd1: begin
                req_misaligned = alu_c[0];
                strb_next      = 4'b0011 << {alu_c[1], 1'b0};
                wdata_next     = {2{rD2[15:0]}};
            end
            2'd2: begin
                req_misaligned = |alu_c[1:0];
            end
            default: begin
                req_misaligned = 1'b1;
            end
        endcase
    end

    // Lane select and extension use the latched address/size, since the
    // core may already be presenting something else on alu_c by then.
    always_comb begin
        load_byte = dbus_rdata[7:0];
        case (lane_q)
            2'd0:    load_byte = dbus_rdata[7:0];
            2'd1:    load_byte = dbus_rdata[15:8];
            2'd2:    load_byte = dbus_rdata[23:16];
            default: load_byte = dbus_rdata[31:24];
        endcase
        load_half = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (size_q)
            2'd0:    load_data = uns_q ? {24'h0, load_byte}
                                       : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_data = uns_q ? {16'h0, load_half}
                                       : {{16{load_half[15]}}, load_half};
            default: load_data = dbus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wstrb <= '0;
            dbus_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        misalign <= 1'b0;
                        bus_err  <= 1'b0;
                        if (req_misaligned) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                            rd_data  <= '0;
                        end else begin
                            state      <= S_BUS;
                            dbus_req   <= 1'b1;
                            dbus_we    <= mem_we;
                            dbus_addr  <= {alu_c[31:2], 2'b00};
                            dbus_wstrb <= mem_we ? strb_next : 4'b0000;
                            dbus_wdata <= mem_we ? wdata_next : 32'h0;
                            lane_q     <= alu_c[1:0];
                            size_q     <= mem_size;
                            uns_q      <= mem_unsigned;
                            tmo_cnt    <= TMO_LOAD;
                        end
                    end
                end
                S_BUS: begin
                    // Ack is tested first so it wins on the timeout edge.
                    if (dbus_ack && dbus_req) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        dbus_req <= 1'b0;
                        dbus_we  <= 1'b0;
                        if (!dbus_we) begin
                            rd_data <= load_data;
                        end
                    end else if ((TIMEOUT > 0) && (tmo_cnt == '0)) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        dbus_req <= 1'b0;
                        dbus_we  <= 1'b0;
                        bus_err  <= 1'b1;
                        rd_data  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
